// File: rtl/sat_clip.sv
// Combinational signed saturation: clamps a wide signed value into W_OUT bits
// and flags which rail, if any, was hit.
module sat_clip #(
   parameter int W_IN  = 33,
   parameter int W_OUT = 18
) (
   input  logic [W_IN-1:0]  i_r,
   output logic [W_OUT-1:0] o_out,
   output logic             o_hi,
   output logic             o_lo
);

   localparam logic signed [W_IN-1:0] MAX_POS = {{(W_IN-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
   localparam logic signed [W_IN-1:0] MIN_NEG = {{(W_IN-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

   logic signed [W_IN-1:0] w_r;
   assign w_r = $signed(i_r);

   always_comb begin
      o_hi  = (w_r > MAX_POS);
      o_lo  = (w_r < MIN_NEG);
      o_out = w_r[W_OUT-1:0];
      if (o_hi)
         o_out = {1'b0, {(W_OUT-1){1'b1}}};
      else if (o_lo)
         o_out = {1'b1, {(W_OUT-1){1'b0}}};
   end

endmodule

// File: rtl/sign_narrow.sv
// Handshaked signed narrowing: round-half-up by FRAC_DROP bits, then saturate
// to WID_OUT bits, with sticky-at-max clip counter for diagnostics.
//
// state   | meaning
// S_WAIT  | idle, accepts a request when arm=1 (latches in)
// S_ROUND | rounded/shifted value R is registered
// S_SAT   | saturated result and clip flags registered, counter bumped
// S_DONE  | result held with finished=1 until arm drops
module sign_narrow #(
   parameter int WID_IN    = 48,
   parameter int FRAC_DROP = 16,
   parameter int WID_OUT   = 18,
   parameter int CNT_WID   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic [WID_IN-1:0]  in,
   output logic [WID_OUT-1:0] out,
   output logic               finished,
   output logic               clipped_hi,
   output logic               clipped_lo,
   input  logic               clr_count,
   output logic [CNT_WID-1:0] sat_count
);

   localparam int R_W = WID_IN - FRAC_DROP + 1;
   // Half an LSB of the kept result; collapses to zero when nothing is dropped.
   localparam logic [WID_IN:0] RND = ((WID_IN+1)'(1) << FRAC_DROP) >> 1;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_ROUND = 2'd1,
      S_SAT   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [WID_IN-1:0]  r_in;
   logic [R_W-1:0]     r_r;
   logic [WID_IN:0]    w_sum;
   logic [WID_OUT-1:0] w_out;
   logic               w_hi, w_lo;
   logic [WID_OUT-1:0] r_out;
   logic               r_fin, r_hi, r_lo;
   logic [CNT_WID-1:0] r_cnt;

   assign w_sum = {r_in[WID_IN-1], r_in} + RND;

   sat_clip #(.W_IN(R_W), .W_OUT(WID_OUT)) u_sat_clip (
      .i_r   (r_r),
      .o_out (w_out),
      .o_hi  (w_hi),
      .o_lo  (w_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_WAIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_WAIT:  if (arm) w_state_nxt = S_ROUND;
         S_ROUND: w_state_nxt = S_SAT;
         S_SAT:   w_state_nxt = S_DONE;
         S_DONE:  if (!arm) w_state_nxt = S_WAIT;
         default: w_state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in  <= '0;
         r_r   <= '0;
         r_out <= '0;
         r_hi  <= 1'b0;
         r_lo  <= 1'b0;
         r_fin <= 1'b0;
      end else begin
         if (r_state == S_WAIT && arm)
            r_in <= in;
         if (r_state == S_ROUND)
            r_r <= R_W'($signed(w_sum) >>> FRAC_DROP);
         if (r_state == S_SAT) begin
            r_out <= w_out;
            r_hi  <= w_hi;
            r_lo  <= w_lo;
         end
         r_fin <= (w_state_nxt == S_DONE);
      end
   end

   // Clear beats a simultaneous increment; counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_count)
         r_cnt <= '0;
      else if (r_state == S_SAT && (w_hi || w_lo) && r_cnt != '1)
         r_cnt <= r_cnt + CNT_WID'(1);
   end

   assign out        = r_out;
   assign finished   = r_fin;
   assign clipped_hi = r_hi;
   assign clipped_lo = r_lo;
   assign sat_count  = r_cnt;

endmodule

// File: doc/sign_narrow.md
# sign_narrow

Pipelined, handshaked signed narrowing unit for the control loop. It takes a wide signed fixed-point value, drops low fractional bits with round-half-up, and saturates the result into a narrower signed word. It sits between the wide PI accumulator and the DAC word path. It reports per-result clip flags and keeps a running saturation count for diagnostics.

## Interface
- WID_IN, 48: input width, signed two's complement.
- FRAC_DROP, 16: low bits removed by rounding. 0 means no rounding. Legal range is 0 ≤ FRAC_DROP ≤ WID_IN−WID_OUT.
- WID_OUT, 18: output width, signed. Requires WID_OUT ≥ 2.
- CNT_WID, 16: width of the saturation counter.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- arm, in, 1: request. It is level-held by the requester until finished is seen.
- in, in, WID_IN: operand. It is sampled only on the accepting edge.
- out, out, WID_OUT: narrowed result. Reset value 0.
- finished, out, 1: result valid. Reset value 0.
- clipped_hi, out, 1: last result saturated positive. Reset value 0.
- clipped_lo, out, 1: last result saturated negative. Reset value 0.
- clr_count, in, 1: synchronous clear of sat_count.
- sat_count, out, CNT_WID: number of clipped results. It sticks at all-ones. Reset value 0.

## Operation
- Arithmetic:
  - Round stage: extend `in` to WID_IN+1 bits. If FRAC_DROP>0, add 2^(FRAC_DROP−1). Then arithmetic shift right by FRAC_DROP. The result is R, of width WID_IN−FRAC_DROP+1 bits. The extra bit guarantees that rounding never wraps.
  - Saturate stage:
    - If R > 2^(WID_OUT−1)−1, out = max positive and clipped_hi = 1.
    - If R < −2^(WID_OUT−1), out = most negative and clipped_lo = 1.
    - Otherwise out = R[WID_OUT−1:0].
  - Rounding is half toward +∞: +1.5 → 2, −1.5 → −1, −2.5 → −2.
- State machine. Encoding is 2 bits, local.
  - WAIT_ARM: if arm=1, latch `in` and go to ROUND.
  - ROUND: register R, then go to SAT.
  - SAT: register out and the clip flags. If clipped, increment sat_count. Set finished=1 and go to DONE.
  - DONE: hold out, the flags, and finished=1. When arm=0, clear finished on that edge and go to WAIT_ARM.
- arm may drop during ROUND or SAT. The computation still completes. finished is high for exactly one cycle in that case, because DONE immediately sees arm=0.
- A new operation can be accepted only from WAIT_ARM. Back-to-back requests therefore need arm low for at least one sampled edge.
- out and the clip flags keep their last values after finished drops. They change only in SAT.
- clr_count and an increment on the same edge: the clear wins, and sat_count = 0.
- sat_count saturates at 2^CNT_WID−1 and never wraps.
- rst asserted in any state:
  - Go to WAIT_ARM.
  - All outputs go to their reset values, including sat_count.
  - Any in-flight result is discarded.

## Timing
- Accept edge E0 is arm=1 sampled in WAIT_ARM.
- R is registered at E0+1. out, the flags, and finished are registered at E0+2. Latency is 2 edges after acceptance, and finished is visible in the cycle after E0+2.
- finished falls on the first edge where arm=0 in DONE.
- Fastest repeat: accept, then 2 cycles to finished, then 1 cycle for arm low, then the next accept. That is 4 cycles per operation.
- clr_count takes effect on the next edge regardless of state.

## Structure
- No shared package. State encodings and rounding constants are localparams inside the block.
- One natural sub-module is `sat_clip`. It is purely combinational and parameterised by input and output widths. It takes R and returns out, clipped_hi and clipped_lo.
  - sign_narrow registers the outputs of sat_clip.
  - Other control-loop blocks reuse sat_clip.
- Expected size: about 150 lines including sat_clip.

## Test plan
All scenarios use the default parameters.
1. Rounding:
   - in=0x000000018000 (+1.5) → out=2.
   - in=−0x18000 → out=−1.
   - in=−0x28000 → out=−2.
   - in=0x00000000_7FFF → out=0.
   - clip flags are 0 in every case.
2. Saturation:
   - in=0x7FFFFFFFFFFF → out=0x1FFFF and clipped_hi=1. Checks that rounding does not wrap.
   - in=0x800000000000 → out=0x20000 and clipped_lo=1.
   - sat_count=2 after both.
3. Boundaries:
   - in=0x1FFFF<<16 → out=0x1FFFF with no clip.
   - in=(0x1FFFF<<16)+0x8000 → clips high.
   - in=−0x20000<<16 → out=0x20000 with no clip.
4. Handshake:
   - Hold arm: finished rises 2 edges after accept and holds while arm=1.
   - Drop arm at E0+1: finished is high for exactly 1 cycle and out is correct.
   - Raise arm again while in DONE: no re-accept until arm has been low once.
5. Counter:
   - Force 2^16+3 clipping operations → sat_count=0xFFFF.
   - Pulse clr_count on the same edge as a clipping SAT → sat_count=0.
6. Reset: assert rst in ROUND → out, finished and the flags are 0 next cycle, sat_count=0, state is WAIT_ARM, and no finished pulse follows.
